// File: rtl/bist_pkg.sv
// Shared BIST definitions: LFSR/MISR polynomials and controller state encoding.
// Used by rr_arbiter_bist and misr_reg.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_CMP,
        ST_DONE
    } bist_state_e;

    // Fibonacci feedback masks (x^4+x^3+1, x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1)
    localparam logic [15:0] LFSR_TAPS_4  = 16'h000C;
    localparam logic [15:0] LFSR_TAPS_8  = 16'h00B8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Internal-XOR MISR polynomials (x^8+x^4+x^3+x^2+1, x^16+x^12+x^5+1)
    localparam logic [15:0] MISR_TAPS_8  = 16'h001D;
    localparam logic [15:0] MISR_TAPS_16 = 16'h1021;

    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] t;
        case (w)
            4:       t = LFSR_TAPS_4;
            16:      t = LFSR_TAPS_16;
            default: t = LFSR_TAPS_8;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] misr_taps(input int w);
        logic [15:0] t;
        case (w)
            16:      t = MISR_TAPS_16;
            default: t = MISR_TAPS_8;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter_bist_if.sv
// Request/grant bundle between requester blocks and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_bist_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0] request;
    logic [N_REQ-1:0] grant_o;

    modport master (
        output request,
        input  grant_o
    );

    modport slave (
        input  request,
        output grant_o
    );
endinterface

// File: rtl/misr_reg.sv
// Multiple-input signature register, internal-XOR form.
// Clear has priority over enable; holds otherwise.
module misr_reg
    import bist_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] signature
);

    localparam logic [W-1:0] POLY = W'(misr_taps(W));

    // Shift with polynomial feedback and fold in the parallel input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= {signature[W-2:0], 1'b0}
                       ^ (signature[W-1] ? POLY : '0)
                       ^ data_in;
        end
    end

endmodule

// File: rtl/rr_arbiter_bist.sv
// Round-robin arbiter with LFSR/MISR built-in self-test.
// Define BIST_SEED_PORT_EN to add a run-time lfsr_seed input.
module rr_arbiter_bist
    import bist_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LFSR_BITS   = 8,
    parameter int MISR_BITS   = 8,
    parameter int TEST_CYCLES = 255,
    parameter logic [LFSR_BITS-1:0] LFSR_SEED  = '1,
    parameter logic [MISR_BITS-1:0] GOLDEN_SIG = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    rr_arbiter_bist_if.slave     arb,
    input  logic                 bist_start,
`ifdef BIST_SEED_PORT_EN
    input  logic [LFSR_BITS-1:0] lfsr_seed,
`endif
    output logic                 bist_end,
    output logic                 pass_fail,
    output logic [MISR_BITS-1:0] signature_out
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TEST_CYCLES + 1);
    localparam logic [LFSR_BITS-1:0] LTAPS =
        LFSR_BITS'(lfsr_taps(LFSR_BITS));
    localparam logic [CW-1:0] LAST = CW'(TEST_CYCLES - 1);
    localparam logic [CW-1:0] TERM = CW'(TEST_CYCLES);

    bist_state_e          state;
    bist_state_e          state_nxt;
    logic                 start_q;
    logic                 start_edge;
    logic                 test_mode;
    logic                 test_q;
    logic [LFSR_BITS-1:0] lfsr;
    logic [LFSR_BITS-1:0] seed_val;
    logic [N_REQ-1:0]     src;
    logic [N_REQ-1:0]     grant_q;
    logic [N_REQ-1:0]     gnt_nxt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_nxt;
    logic                 found;
    logic [CW-1:0]        count;
    logic [MISR_BITS-1:0] misr_din;

`ifdef BIST_SEED_PORT_EN
    assign seed_val = (lfsr_seed == '0) ? LFSR_SEED : lfsr_seed;
`else
    assign seed_val = LFSR_SEED;
`endif

    assign start_edge = bist_start & ~start_q;
    assign test_mode  = (state == ST_SEED) || (state == ST_RUN) ||
                        (state == ST_CMP);
    assign src        = test_mode ? lfsr[N_REQ-1:0] : arb.request;
    assign bist_end   = (state == ST_DONE);

    // Grants computed from test patterns never reach the functional side
    assign arb.grant_o = (test_mode || test_q) ? '0 : grant_q;

    // State register and start-edge detector
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= bist_start;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start_edge) state_nxt = ST_SEED;
            ST_SEED: state_nxt = ST_RUN;
            ST_RUN:  if (count == LAST) state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_DONE;
            ST_DONE: if (start_edge) state_nxt = ST_SEED;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin search: indices at/after the pointer first, then wrap
    always_comb begin
        gnt_nxt = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && src[i] && (PW'(i) >= ptr)) begin
                found      = 1'b1;
                gnt_nxt[i] = 1'b1;
                ptr_nxt    = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && src[i]) begin
                found      = 1'b1;
                gnt_nxt[i] = 1'b1;
                ptr_nxt    = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Grant and pointer registers, cleared when a test is seeded
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            ptr     <= '0;
            test_q  <= 1'b0;
        end else if (state == ST_SEED) begin
            grant_q <= '0;
            ptr     <= '0;
            test_q  <= 1'b1;
        end else begin
            grant_q <= gnt_nxt;
            ptr     <= ptr_nxt;
            test_q  <= test_mode;
        end
    end

    // Pattern generator: load in SEED, step through RUN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_SEED) begin
            lfsr <= seed_val;
        end else if (state == ST_RUN) begin
            lfsr <= {lfsr[LFSR_BITS-2:0], ^(lfsr & LTAPS)};
        end
    end

    // Run-length counter, saturating at its terminal value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == ST_SEED) begin
            count <= '0;
        end else if (state == ST_RUN && count != TERM) begin
            count <= count + 1'b1;
        end
    end

    // Verdict captured once, then held through DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_fail <= 1'b0;
        end else if (state == ST_SEED) begin
            pass_fail <= 1'b0;
        end else if (state == ST_CMP) begin
            pass_fail <= (signature_out == GOLDEN_SIG);
        end
    end

    // Zero-extend the internal grant into the signature input
    always_comb begin
        misr_din              = '0;
        misr_din[N_REQ-1:0]   = grant_q;
    end

    misr_reg #(
        .W (MISR_BITS)
    ) u_misr (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == ST_SEED),
        .enable    (state == ST_RUN),
        .data_in   (misr_din),
        .signature (signature_out)
    );

endmodule

// File: tb/tb_rr_arbiter_bist.sv
// Directed bench for rr_arbiter_bist: functional arbitration and BIST runs.
// Instance b uses a short run with a hand-derived golden signature.
module tb_rr_arbiter_bist;

    logic       clock;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic       end_a;
    logic       end_b;
    logic       pass_a;
    logic       pass_b;
    logic [7:0] sig_a;
    logic [7:0] sig_b;
`ifdef BIST_SEED_PORT_EN
    logic [7:0] seed_a;
    logic [7:0] seed_b;
`endif

    int tests;
    int fails;
    int n;
    bit saw;
    logic [7:0] sig1;
    logic [7:0] ref_sig;

    rr_arbiter_bist_if #(.N_REQ(4)) ifa ();
    rr_arbiter_bist_if #(.N_REQ(4)) ifb ();

    rr_arbiter_bist dut_a (
        .clock         (clock),
        .reset         (reset),
        .arb           (ifa),
        .bist_start    (start_a),
`ifdef BIST_SEED_PORT_EN
        .lfsr_seed     (seed_a),
`endif
        .bist_end      (end_a),
        .pass_fail     (pass_a),
        .signature_out (sig_a)
    );

    rr_arbiter_bist #(
        .TEST_CYCLES (4),
        .GOLDEN_SIG  (8'h04)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .arb           (ifb),
        .bist_start    (start_b),
`ifdef BIST_SEED_PORT_EN
        .lfsr_seed     (seed_b),
`endif
        .bist_end      (end_b),
        .pass_fail     (pass_b),
        .signature_out (sig_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: default-parameter test run (seed FF, x^8+x^6+x^5+x^4+1 LFSR)
    function automatic logic [7:0] model_sig(input int cycles);
        logic [7:0] l;
        logic [7:0] m;
        logic [3:0] g;
        logic [3:0] gn;
        int p;
        int j;
        bit hit;
        l = 8'hFF;
        m = 8'h00;
        g = 4'h0;
        p = 0;
        for (int c = 0; c < cycles; c++) begin
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {4'h0, g};
            gn  = 4'h0;
            hit = 1'b0;
            for (int k = 0; k < 4; k++) begin
                j = (p + k) % 4;
                if (!hit && l[j]) begin
                    gn[j] = 1'b1;
                    hit   = 1'b1;
                    p     = (j + 1) % 4;
                end
            end
            g = gn;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return m;
    endfunction

    task automatic wait_end_a(output int cnt);
        cnt = 0;
        while (!end_a && cnt < 2000) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.request = 4'h0;
        ifb.request = 4'h0;
`ifdef BIST_SEED_PORT_EN
        seed_a = 8'h00;
        seed_b = 8'h00;
`endif
        ref_sig = model_sig(255);
        #2;
        check("rst_grant", {28'h0, ifa.grant_o}, 32'h0);
        check("rst_end", {31'h0, end_a}, 32'h0);
        check("rst_pass", {31'h0, pass_a}, 32'h0);
        check("rst_sig", {24'h0, sig_a}, 32'h0);
        #10;
        reset = 1'b1;

        // All requesting: pointer rotates through every requester
        ifa.request = 4'b1111;
        tick(); check("rr_all0", {28'h0, ifa.grant_o}, 32'h1);
        tick(); check("rr_all1", {28'h0, ifa.grant_o}, 32'h2);
        tick(); check("rr_all2", {28'h0, ifa.grant_o}, 32'h4);
        tick(); check("rr_all3", {28'h0, ifa.grant_o}, 32'h8);
        tick(); check("rr_all4", {28'h0, ifa.grant_o}, 32'h1);

        reset = 1'b0;
        ifa.request = 4'b1010;
        #4;
        reset = 1'b1;
        tick(); check("rr_1010a", {28'h0, ifa.grant_o}, 32'h2);
        tick(); check("rr_1010b", {28'h0, ifa.grant_o}, 32'h8);
        ifa.request = 4'b0000;
        tick(); check("rr_none", {28'h0, ifa.grant_o}, 32'h0);
        ifa.request = 4'b1111;
        tick(); check("rr_held", {28'h0, ifa.grant_o}, 32'h1);

        // Short run on instance b: 4 updates, signature 8'h04
        ifb.request = 4'b1111;
        start_b = 1'b1;
        tick();
        n = 0;
        saw = 1'b0;
        while (!end_b && n < 2000) begin
            if (ifb.grant_o !== 4'h0) saw = 1'b1;
            tick();
            n++;
        end
        if (ifb.grant_o !== 4'h0) saw = 1'b1;
        check("b_latency", n, 32'd6);
        check("b_sig", {24'h0, sig_b}, 32'h04);
        check("b_pass", {31'h0, pass_b}, 32'h1);
        check("b_no_grant", {31'h0, saw}, 32'h0);
        tick();
        check("b_func_resume", {28'h0, ifb.grant_o}, 32'h1);
        check("b_end_held", {31'h0, end_b}, 32'h1);

        // Full default run on instance a, twice
        start_a = 1'b1;
        tick();
        wait_end_a(n);
        check("a_latency", n, 32'd257);
        check("a_sig", {24'h0, sig_a}, {24'h0, ref_sig});
        check("a_pass", {31'h0, pass_a},
              (ref_sig == 8'h00) ? 32'h1 : 32'h0);
        sig1 = sig_a;
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        wait_end_a(n);
        check("a_rerun_latency", n, 32'd257);
        check("a_rerun_sig", {24'h0, sig_a}, {24'h0, sig1});

        // Reset mid-run aborts; a fresh start completes normally
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        reset = 1'b0;
        start_a = 1'b0;
        #1;
        check("abort_end", {31'h0, end_a}, 32'h0);
        check("abort_pass", {31'h0, pass_a}, 32'h0);
        check("abort_sig", {24'h0, sig_a}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("abort_idle", {31'h0, end_a}, 32'h0);
        start_a = 1'b1;
        tick();
        wait_end_a(n);
        check("post_latency", n, 32'd257);
        check("post_sig", {24'h0, sig_a}, {24'h0, sig1});
        check("post_pass", {31'h0, pass_a},
              (ref_sig == 8'h00) ? 32'h1 : 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
